// File: rtl/aes256_encrypt_core.sv
// AES-256 encrypt-only block engine: iterative key expansion (one word per clock)
// into a 15-entry round-key RAM, then one cipher round per clock per 128-bit block.
module aes256_encrypt_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         pi_key_expand_start,
    input  logic [255:0] pi_master_key,
    output logic         po_key_ready,
    output logic         s_axis_tready,
    input  logic         s_axis_tvalid,
    input  logic [127:0] s_axis_tdata,
    output logic         po_data_valid,
    output logic [127:0] po_data
);

    localparam logic [1:0] K_IDLE   = 2'd0;
    localparam logic [1:0] K_EXPAND = 2'd1;
    localparam logic [1:0] K_READY  = 2'd2;
    localparam logic [0:0] C_IDLE   = 1'b0;
    localparam logic [0:0] C_BUSY   = 1'b1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a};
        return d[15-n -: 8];
    endfunction

    // Inverse as x^254 = x^2 * x^4 * ... * x^128, then the FIPS affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gmul(x, x);
        inv = sq;
        for (int k = 2; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [1:0]   r_kstate;
    logic [5:0]   r_widx;
    logic [31:0]  r_win [8];
    logic [127:0] r_rk_mem [15];
    logic [127:0] r_rk_q;
    logic [0:0]   r_cstate;
    logic [3:0]   r_round;
    logic [127:0] r_state;

    logic [31:0]  w_sub;
    logic [31:0]  w_rot_sub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_new;
    logic         w_rk_we;
    logic [3:0]   w_rk_waddr;
    logic [127:0] w_rk_wdata;
    logic [3:0]   w_rd_addr;
    logic         w_accept;
    logic [7:0]   w_sb [16];
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_round_out;

    assign po_key_ready  = (r_kstate == K_READY);
    assign s_axis_tready = po_key_ready && (r_cstate == C_IDLE);
    assign w_accept      = s_axis_tvalid && s_axis_tready && !pi_key_expand_start;

    // Key schedule: r_win is a sliding window holding w[i-8] .. w[i-1].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign w_sub[31-8*gi -: 8] = sbox(r_win[7][31-8*gi -: 8]);
        end
    endgenerate

    assign w_rot_sub = {w_sub[23:0], w_sub[31:24]};
    assign w_rcon    = 8'h01 << (r_widx[5:3] - 3'd1);

    always_comb begin
        w_new = r_win[0] ^ r_win[7];
        if (r_widx[2:0] == 3'd0)
            w_new = r_win[0] ^ w_rot_sub ^ {w_rcon, 24'h000000};
        else if (r_widx[2:0] == 3'd4)
            w_new = r_win[0] ^ w_sub;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kstate <= K_IDLE;
            r_widx   <= 6'd8;
        end else if (pi_key_expand_start) begin
            r_kstate <= K_EXPAND;
            r_widx   <= 6'd8;
        end else if (r_kstate == K_EXPAND) begin
            r_widx <= r_widx + 6'd1;
            if (r_widx == 6'd59) r_kstate <= K_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (pi_key_expand_start) begin
            for (int k = 0; k < 8; k++) r_win[k] <= pi_master_key[255-32*k -: 32];
        end else if (r_kstate == K_EXPAND) begin
            for (int k = 0; k < 7; k++) r_win[k] <= r_win[k+1];
            r_win[7] <= w_new;
        end
    end

    // One RAM write per cycle: rk0/rk1 are drained from the window on the first two
    // expansion cycles, every later key is written as its fourth word is produced.
    always_comb begin
        w_rk_we    = (r_kstate == K_EXPAND) && !pi_key_expand_start &&
                     (r_widx == 6'd8 || r_widx == 6'd9 || r_widx[1:0] == 2'd3);
        w_rk_waddr = r_widx[5:2];
        w_rk_wdata = {r_win[5], r_win[6], r_win[7], w_new};
        if (r_widx == 6'd8) begin
            w_rk_waddr = 4'd0;
            w_rk_wdata = {r_win[0], r_win[1], r_win[2], r_win[3]};
        end else if (r_widx == 6'd9) begin
            w_rk_waddr = 4'd1;
            w_rk_wdata = {r_win[3], r_win[4], r_win[5], r_win[6]};
        end
    end

    // Read address runs one round ahead; rk0 is prefetched whenever the next edge could accept.
    always_comb begin
        w_rd_addr = 4'd0;
        if (r_cstate == C_BUSY)
            w_rd_addr = (r_round == 4'd14) ? 4'd0 : r_round + 4'd1;
        else if (w_accept)
            w_rd_addr = 4'd1;
    end

    always_ff @(posedge clk) begin
        if (w_rk_we) r_rk_mem[w_rk_waddr] <= w_rk_wdata;
        r_rk_q <= r_rk_mem[w_rd_addr];
    end

    // Round datapath; state byte gi sits at bits [127-8*gi] (row gi%4, column gi/4).
    generate
        for (gi = 0; gi < 16; gi++) begin : g_round_sbox
            assign w_sb[gi] = sbox(r_state[127-8*gi -: 8]);
            assign w_shift[127-8*gi -: 8] = w_sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
        end
        for (gi = 0; gi < 4; gi++) begin : g_mixcol
            assign w_mix[127-32*gi -: 32] = mixcol(w_shift[127-32*gi -: 32]);
        end
    endgenerate

    assign w_round_out = ((r_round == 4'd14) ? w_shift : w_mix) ^ r_rk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate      <= C_IDLE;
            r_round       <= 4'd0;
            r_state       <= '0;
            po_data       <= '0;
            po_data_valid <= 1'b0;
        end else begin
            po_data_valid <= 1'b0;
            if (pi_key_expand_start) begin
                r_cstate <= C_IDLE;
            end else if (r_cstate == C_IDLE) begin
                if (w_accept) begin
                    r_state  <= s_axis_tdata ^ r_rk_q;
                    r_round  <= 4'd1;
                    r_cstate <= C_BUSY;
                end
            end else begin
                r_state <= w_round_out;
                if (r_round == 4'd14) begin
                    po_data       <= w_round_out;
                    po_data_valid <= 1'b1;
                    r_cstate      <= C_IDLE;
                end else begin
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Directed bench for aes256_encrypt_core using FIPS-197 / SP800-38A vectors;
// outputs are sampled and inputs driven on the falling clock edge.
module tb_aes256_encrypt_core;

    localparam logic [255:0] K_NIST = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] K_SEQ  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] C1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] C2 = 128'h591ccb10d410ed26dc5ba74a31362870;
    localparam logic [127:0] C3 = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
    localparam logic [127:0] C4 = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;
    localparam logic [127:0] PS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CS = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic         tvalid;
    logic [127:0] tdata;
    logic         key_ready;
    logic         tready;
    logic         dvalid;
    logic [127:0] dout;

    int n_total = 0;
    int n_bad   = 0;

    aes256_encrypt_core dut (
        .clk                 (clk),
        .rst                 (rst),
        .pi_key_expand_start (start),
        .pi_master_key       (key),
        .po_key_ready        (key_ready),
        .s_axis_tready       (tready),
        .s_axis_tvalid       (tvalid),
        .s_axis_tdata        (tdata),
        .po_data_valid       (dvalid),
        .po_data             (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [255:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the falling edge right after the start edge.
    task automatic wait_ready(input string tag);
        int n;
        logic stray;
        n = 0;
        stray = 1'b0;
        while (!key_ready && n < 200) begin
            if (dvalid || tready) stray = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, "_key_latency"}, 128'(n), 128'(52));
        check({tag, "_no_stray"}, 128'(stray), 128'(0));
        check({tag, "_tready"}, 128'(tready), 128'(1));
        $display("key %s: ready after %0d cycles", tag, n);
    endtask

    // Offers pt, waits for the handshake, loads the next offer, then returns on
    // the falling edge of the cycle in which the ciphertext strobe is high.
    task automatic send(input logic [127:0] pt, input logic [127:0] exp,
                        input logic nxt_v, input logic [127:0] nxt_pt, input string tag);
        int n;
        int k;
        logic early;
        tvalid = 1'b1;
        tdata  = pt;
        n = 0;
        while (!tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check({tag, "_handshake_timeout"}, 128'(tready), 128'(1));
            tvalid = 1'b0;
            return;
        end
        @(negedge clk);
        tvalid = nxt_v;
        tdata  = nxt_pt;
        k = 0;
        early = 1'b0;
        while (!dvalid && k < 40) begin
            if (tready) early = 1'b1;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 128'(k), 128'(14));
        check({tag, "_tready_low"}, 128'(early), 128'(0));
        check({tag, "_data"}, dout, exp);
        check({tag, "_tready_back"}, 128'(tready), 128'(1));
        $display("blk %s: pt=%h ct=%h wait=%0d lat=%0d", tag, pt, dout, n, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic stray;
        rst = 1'b1; start = 1'b0; key = '0; tvalid = 1'b0; tdata = '0;
        repeat (3) @(negedge clk);
        check("rst_key_ready", 128'(key_ready), 128'(0));
        check("rst_tready", 128'(tready), 128'(0));
        check("rst_valid", 128'(dvalid), 128'(0));
        check("rst_data", dout, 128'(0));
        rst = 1'b0;
        @(negedge clk);

        pulse_start(K_NIST);
        check("start_drop", 128'(key_ready), 128'(0));
        wait_ready("nist");

        // Back-to-back stream, tdata advanced right after each handshake.
        send(P1, C1, 1'b1, P2, "nist1");
        send(P2, C2, 1'b1, P3, "nist2");
        send(P3, C3, 1'b1, P4, "nist3");
        send(P4, C4, 1'b0, '0, "nist4");
        @(negedge clk);
        check("strobe_single", 128'(dvalid), 128'(0));
        check("data_hold", dout, C4);

        pulse_start(K_SEQ);
        wait_ready("seq");
        send(PS, CS, 1'b0, '0, "seq");

        // Restart mid-block while the next block is already offered.
        tvalid = 1'b1; tdata = PS;
        while (!tready) @(negedge clk);
        @(negedge clk);
        tvalid = 1'b0;
        repeat (4) @(negedge clk);
        tvalid = 1'b1; tdata = P1;
        pulse_start(K_NIST);
        wait_ready("restart");
        send(P1, C1, 1'b0, '0, "restart");

        // Start and handshake in the same cycle: start wins, block stays pending.
        @(negedge clk);
        check("contend_tready", 128'(tready), 128'(1));
        tvalid = 1'b1; tdata = P2;
        pulse_start(K_NIST);
        wait_ready("contend");
        send(P2, C2, 1'b0, '0, "contend");

        // Reset mid-block.
        tvalid = 1'b1; tdata = P3;
        while (!tready) @(negedge clk);
        @(negedge clk);
        tvalid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstblk_key_ready", 128'(key_ready), 128'(0));
        check("rstblk_tready", 128'(tready), 128'(0));
        check("rstblk_valid", 128'(dvalid), 128'(0));
        check("rstblk_data", dout, 128'(0));
        stray = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (dvalid || key_ready || tready) stray = 1'b1;
        end
        check("rstblk_quiet", 128'(stray), 128'(0));

        // Reset mid-expansion: ready must not come back without a new start.
        pulse_start(K_NIST);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstexp_key_ready", 128'(key_ready), 128'(0));
        check("rstexp_tready", 128'(tready), 128'(0));
        stray = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (dvalid || key_ready || tready) stray = 1'b1;
        end
        check("rstexp_quiet", 128'(stray), 128'(0));

        pulse_start(K_SEQ);
        wait_ready("final");
        send(PS, CS, 1'b0, '0, "final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/aes256_encrypt_core.md
Name: aes256_encrypt_core

Overview:
- AES-256 block encryption engine, encrypt direction only, per FIPS-197.
- On a start pulse it latches a 256-bit master key and iteratively expands it into 15 stored round keys.
- It then accepts 128-bit plaintext blocks over an AXI-Stream-style slave handshake and computes one round per clock.
- Each ciphertext is presented with a single-cycle valid strobe. It serves as the block-cipher primitive beneath a CTR-mode wrapper, which supplies counter blocks.

Parameters:
- None. Key size 256 bits, 14 rounds, 128-bit block; all fixed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pi_key_expand_start  in  1  one-cycle pulse; latch pi_master_key and start key expansion
- pi_master_key  in  256  master key; bit 255 is MSB of key byte 0
- po_key_ready  out  1  high when all 15 round keys are valid
- s_axis_tready  out  1  core can accept a block this cycle
- s_axis_tvalid  in  1  plaintext valid
- s_axis_tdata  in  128  plaintext; bits 127:120 = state byte 0 (FIPS column-major order)
- po_data_valid  out  1  one-cycle strobe; po_data holds ciphertext
- po_data  out  128  ciphertext, same byte order as s_axis_tdata

Behaviour:
- Reset (clk edge with rst=1): po_key_ready=0, s_axis_tready=0, po_data_valid=0, po_data=0; key FSM to IDLE; cipher FSM to IDLE; round-key storage contents don't-care.
- Key FSM states:
  - IDLE: on start, latch key as words w0..w7 and go to EXPAND.
  - EXPAND: one 32-bit word per cycle, w8..w59.
    - i mod 8 == 0: w[i-8] ^ SubWord(RotWord(w[i-1])) ^ Rcon[i/8], Rcon = 01,02,04,08,10,20,40 in the MS byte.
    - i mod 8 == 4: w[i-8] ^ SubWord(w[i-1]).
    - Otherwise: w[i-8] ^ w[i-1].
  - READY: entered after w59 is written, i.e. 52 cycles after the start edge; po_key_ready=1 there.
- po_key_ready drops the cycle after any start pulse. A start pulse in any state, including EXPAND or during encryption, restarts expansion with the new key. Any in-flight block is aborted and produces no po_data_valid.
- s_axis_tready = po_key_ready AND cipher IDLE. Blocks offered while tready=0 are not consumed; the upstream source holds them (AXI rule: tvalid must not depend on tready).
- Cipher FSM:
  - On the edge where tvalid & tready: state <= tdata ^ rk0, round counter = 1, go BUSY; tready falls the next cycle.
  - BUSY, rounds 1..13: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk_r).
  - Round 14: SubBytes, ShiftRows, AddRoundKey(rk14), no MixColumns. Result is registered into po_data with po_data_valid=1, and the FSM returns to IDLE.
- Latency: acceptance at edge T gives po_data_valid high for exactly the cycle following edge T+14. tready is high again in that same cycle, so throughput is one block per 15 cycles.
- po_data holds its last value after the valid strobe; valid is low otherwise.
- S-box: shared combinational function (table or GF(2^8) inverse plus affine); 16 instances for the datapath, 4 for key expansion.
- Reset mid-expansion or mid-block: everything returns to reset values; a new start pulse is required.
- tvalid asserted before the key is ready: the block is held and accepted on the first cycle tready=1.
- Simultaneous start and tvalid&tready in the same cycle: start wins; the block is not accepted.

Test Plan:
- Reset, then NIST key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 start -> po_key_ready rises 52 cycles after the pulse; tready=1 that same cycle.
- Hold tvalid with 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51, 30c81c46a35ce411e5fbc1191a0a52ef, f69f2445df4f9b17ad2b417be66c3710, updating tdata after each handshake -> outputs in order:
  - f3eed1bdb5d2a03c064b5a7e3db181f8
  - 591ccb10d410ed26dc5ba74a31362870
  - b6ed21b99ca6f4f9f153e7b1beafed1d
  - 23304b7a39f9f3ff067d8d8f9e24ecc7
  - Each output is a single-cycle strobe 14 cycles after its handshake; tready is low between.
- New key 000102...1e1f start, then plaintext 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089.
- Start pulse issued mid-block -> no po_data_valid for that block; po_key_ready=0 for 52 cycles, then the correct result with the new key.
- tvalid high before po_key_ready -> no handshake until key ready, then the correct ciphertext.
- rst asserted mid-block and mid-expansion -> all outputs 0 the next cycle; no stray valid after reset is released.
